// File: rtl/result_stream_out_pkg.sv
// Shared conv-engine constants and the drain-stage FSM state encoding.
package result_stream_out_pkg;

  localparam int DEF_RESULT_W = 32;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_SHIFT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/result_stream_out_if.sv
// Valid/ready sample stream carrying one requantized result per beat plus a last flag.
interface result_stream_out_if
  import result_stream_out_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) ();

  logic             valid;
  logic             ready;
  logic [OUT_W-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/result_fifo2.sv
// Two-entry valid/ready FIFO; output comes straight from storage flops and count is exposed
// so the producer can meter its reads against free space.
module result_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: storage is left unreset; the pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/result_stream_out.sv
// Drain stage: reads a block of conv results from the result RAM, requantizes each one and
// streams it out, metering reads so the 2-entry output FIFO can never overflow.
module result_stream_out
  import result_stream_out_pkg::*;
#(
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int SHIFT_W  = DEF_SHIFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_results,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic                relu_en,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [RESULT_W-1:0] ram_dout,
  result_stream_out_if.master m,
  output logic                busy,
  output logic                done
);

  localparam logic signed [RESULT_W:0] SAT_HI = (RESULT_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RESULT_W:0] SAT_LO = ~SAT_HI;

  // Rounding shift is done one bit wider than the stored result so the +half term cannot wrap.
  function automatic logic [OUT_W-1:0] requant(input logic [RESULT_W-1:0] x,
                                               input logic [SHIFT_W-1:0]  sh,
                                               input logic                relu);
    logic signed [RESULT_W:0] ext;
    logic signed [RESULT_W:0] rnd;
    logic signed [RESULT_W:0] y;
    ext = {x[RESULT_W-1], x};
    rnd = '0;
    if (sh != '0) begin
      rnd = {{RESULT_W{1'b0}}, 1'b1} << (sh - SHIFT_W'(1));
      y   = (ext + rnd) >>> sh;
    end else begin
      y = ext;
    end
    if (relu && (y < 0)) y = '0;
    if (y > SAT_HI)      y = SAT_HI;
    else if (y < SAT_LO) y = SAT_LO;
    return OUT_W'(y);
  endfunction

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, num_q, issue_cnt_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 relu_q;
  logic                 inflight_q, inflight_last_q;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 pop;
  logic                 last_issue;
  logic                 credit_ok;
  logic [1:0]           fifo_count;
  logic [2:0]           occupancy;

  assign pop        = m.valid && m.ready;
  assign last_issue = (issue_cnt_q == (num_q - ADDR_W'(1)));
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok  = (occupancy < 3'd2);
  assign ram_addr   = base_q + issue_cnt_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    ram_en  = 1'b0;
    accept  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          accept = 1'b1;
          if (num_results == '0) done_d  = 1'b1;
          else                   state_d = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          ram_en = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish in the cycle of the final handshake so done lands one cycle after it.
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q          <= '0;
      num_q           <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= done_d;
      inflight_q      <= ram_en;
      inflight_last_q <= ram_en && last_issue;
      if (accept) begin
        base_q      <= base_addr;
        num_q       <= num_results;
        shift_q     <= shift;
        relu_q      <= relu_en;
        issue_cnt_q <= '0;
      end else if (ram_en) begin
        issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
      end
    end
  end

  result_fifo2 #(.W(OUT_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   ({inflight_last_q, requant(ram_dout, shift_q, relu_q)}),
    .out_valid (m.valid),
    .out_ready (m.ready),
    .out_data  ({m.last, m.data}),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_result_stream_out.sv
// Self-checking bench for result_stream_out: directed scenarios plus randomized runs scored
// against an arithmetic requantization model and an expected-beat queue.
module tb_result_stream_out;
  import result_stream_out_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr, num_results;
  logic [4:0]  shift;
  logic        relu_en;
  logic        ram_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_dout = '0;
  logic        busy, done;

  result_stream_out_if #(.OUT_W(8)) m_if ();

  result_stream_out dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_results(num_results),
    .shift(shift), .relu_en(relu_en), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m(m_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [65536];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  logic [15:0] addr_q[$];
  int          cyc = 0, beat_cnt = 0, done_cnt = 0, outstanding = 0;
  int          start_cyc = 0, first_valid_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit          valid_seen = 0, busy_seen = 0, stalled_prev = 0;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-half-up division by 2^sh via floor division, then ReLU and int8 saturation.
  function automatic logic [7:0] ref_q(input logic [31:0] raw, input int sh, input bit relu);
    longint x, p, y;
    x = longint'($signed(raw));
    if (sh == 0) y = x;
    else begin
      p = longint'(1) << sh;
      y = x + p / 2;
      y = (y >= 0) ? y / p : -((-y + p - 1) / p);
    end
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    else if (y < -128) y = -128;
    return y[7:0];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled_prev = 0;
    end else begin
      if (busy) busy_seen = 1;
      if (m_if.valid && !valid_seen) begin
        valid_seen      = 1;
        first_valid_cyc = cyc;
      end
      if (busy) check("outstanding_le2", (outstanding <= 2), 1);
      if (stalled_prev) begin
        check("stall_valid", m_if.valid, 1);
        check("stall_data", m_if.data, prev_data);
        check("stall_last", m_if.last, prev_last);
      end
      if (m_if.valid && m_if.ready) begin
        check("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", m_if.data, b.data);
          check("beat_last", m_if.last, b.last);
        end
        beat_cnt++;
        last_hs_cyc = cyc;
      end
      if (ram_en) addr_q.push_back(ram_addr);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      outstanding  = outstanding + int'(ram_en) - int'(m_if.valid && m_if.ready);
      stalled_prev = m_if.valid && !m_if.ready;
      prev_data    = m_if.data;
      prev_last    = m_if.last;
    end
  end

  task automatic drive_ready(input int mode, input int ph);
    case (mode)
      0: m_if.ready = 1'b1;
      1: m_if.ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      2: m_if.ready = 1'($urandom_range(0, 1));
      default: m_if.ready = 1'b0;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after start was sampled.
  task automatic launch(input logic [15:0] b, input logic [15:0] n, input int sh, input bit relu);
    logic [15:0] a;
    for (int i = 0; i < int'(n); i++) begin
      beat_t e;
      a      = b + 16'(i);
      e.data = ref_q(mem[a], sh, relu);
      e.last = (i == int'(n) - 1);
      exp_q.push_back(e);
    end
    addr_q.delete();
    beat_cnt = 0; done_cnt = 0; valid_seen = 0; busy_seen = 0;
    base_addr = b; num_results = n; shift = 5'(sh); relu_en = relu;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int mode, input int max_cyc);
    bit got = 0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      drive_ready(mode, c);
      @(negedge clk);
      got = done;
      @(posedge clk); #1;
    end
    check("done_seen", got, 1);
  endtask

  task automatic fill_random(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++)
      mem[16'(b + 16'(i))] = ($urandom_range(0, 3) == 0) ? $urandom
                                                          : 32'(int'($urandom_range(0, 4000)) - 2000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_results = '0; shift = '0; relu_en = 1'b0;
    m_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_if.valid, 0);
    check("rst_data", m_if.data, 0);
    check("rst_last", m_if.last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_en", ram_en, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic stream with latency and done timing
    mem[0] = 32'd100; mem[1] = -32'sd100; mem[2] = 32'd300; mem[3] = 32'd5;
    m_if.ready = 1'b1;
    launch(16'd0, 16'd4, 2, 1'b0);
    check("basic_ram_en", ram_en, 1);
    check("basic_addr", ram_addr, 0);
    check("basic_busy", busy, 1);
    run_until_done(0, 50);
    check("basic_first_valid", first_valid_cyc - start_cyc, 3);
    check("basic_done_after_last", done_cyc - last_hs_cyc, 1);
    check("basic_beats", beat_cnt, 4);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_leftover", exp_q.size(), 0);

    // Saturation and ReLU
    mem[16] = 32'd1000; mem[17] = -32'sd1000; mem[18] = -32'sd3;
    for (int r = 1; r >= 0; r--) begin
      launch(16'd16, 16'd3, 0, 1'(r));
      run_until_done(0, 50);
      check("sat_beats", beat_cnt, 3);
      check("sat_leftover", exp_q.size(), 0);
    end

    // Backpressure 1,0,0,1 with 8 results
    fill_random(16'd100, 8);
    launch(16'd100, 16'd8, 3, 1'b0);
    run_until_done(1, 200);
    check("bp_beats", beat_cnt, 8);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_leftover", exp_q.size(), 0);

    // Zero-length, then a start coincident with done
    launch(16'd5, 16'd0, 1, 1'b0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    num_results = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_on_done_ignored", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_valid_seen", valid_seen, 0);
    check("zero_busy_seen", busy_seen, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Address wrap
    fill_random(16'hFFFE, 3);
    launch(16'hFFFE, 16'd3, 4, 1'b1);
    run_until_done(2, 100);
    check("wrap_addr_cnt", addr_q.size(), 3);
    for (int i = 0; i < 3 && i < addr_q.size(); i++)
      check("wrap_addr", addr_q[i], 16'(32'hFFFE + i));
    check("wrap_beats", beat_cnt, 3);

    // Reset mid-run with the FIFO full
    fill_random(16'd200, 8);
    m_if.ready = 1'b0;
    launch(16'd200, 16'd8, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_before", busy, 1);
    check("mid_valid_before", m_if.valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_valid_after", m_if.valid, 0);
    check("mid_busy_after", busy, 0);
    check("mid_ram_en_after", ram_en, 0);
    rst = 1'b0;
    exp_q.delete(); outstanding = 0; stalled_prev = 0; done_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt, 0);
    fill_random(16'd300, 5);
    m_if.ready = 1'b1;
    launch(16'd300, 16'd5, 2, 1'b1);
    check("mid_new_addr", ram_addr, 16'd300);
    run_until_done(0, 50);
    check("mid_beats", beat_cnt, 5);

    // Start while busy
    fill_random(16'd400, 6);
    launch(16'd400, 16'd6, 2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive_ready(2, c);
      start = (c == 1); base_addr = 16'd900; num_results = 16'd2;
      @(posedge clk); #1;
    end
    start = 1'b0;
    run_until_done(2, 200);
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_beats", beat_cnt, 6);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_leftover", exp_q.size(), 0);

    // Randomized runs
    for (int t = 0; t < 8; t++) begin
      logic [15:0] b;
      int          n, sh, mode;
      b    = 16'($urandom);
      n    = int'($urandom_range(1, 20));
      sh   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 2));
      fill_random(b, n);
      launch(b, 16'(n), sh, 1'($urandom_range(0, 1)));
      run_until_done(mode, 400);
      check("rand_beats", beat_cnt, n);
      check("rand_leftover", exp_q.size(), 0);
      exp_q.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
